// File: rtl/ddr4_v2_2_20_axi_rd_resp_packer_if.sv
// Bundle of tag, MC read-data and AXI R-channel signals for the read response packer.
// The slave modport is the packer's view; master is the surrounding logic.
interface ddr4_v2_2_20_axi_rd_resp_packer_if #(
    parameter int unsigned C_ID_WIDTH   = 4,
    parameter int unsigned C_DATA_WIDTH = 32
);
    logic                      tag_valid;
    logic                      tag_ready;
    logic [C_ID_WIDTH-1:0]     tag_id;
    logic                      tag_ignore_begin;
    logic                      tag_ignore_end;
    logic                      tag_last;

    logic                      mc_rd_valid;
    logic                      mc_rd_ready;
    logic [2*C_DATA_WIDTH-1:0] mc_rd_data;

    logic                      rvalid;
    logic                      rready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    logic [C_ID_WIDTH-1:0]     rid;
    logic [1:0]                rresp;
    logic                      rlast;

    logic                      err_both_ignore;

    modport master (
        output tag_valid, tag_id, tag_ignore_begin, tag_ignore_end, tag_last,
        output mc_rd_valid, mc_rd_data, rready,
        input  tag_ready, mc_rd_ready, rvalid, rdata, rid, rresp, rlast, err_both_ignore
    );

    modport slave (
        input  tag_valid, tag_id, tag_ignore_begin, tag_ignore_end, tag_last,
        input  mc_rd_valid, mc_rd_data, rready,
        output tag_ready, mc_rd_ready, rvalid, rdata, rid, rresp, rlast, err_both_ignore
    );
endinterface

// File: rtl/ddr4_v2_2_20_axi_rd_resp_packer.sv
// Pairs MC read words (two beats each) with queued command tags and emits an AXI R stream.
// Optional DDR4_AXI_RD_RESP_SKID_EN inserts a 2-entry skid buffer ahead of the R outputs.
module ddr4_v2_2_20_axi_rd_resp_packer #(
    parameter int unsigned C_ID_WIDTH       = 4,
    parameter int unsigned C_DATA_WIDTH     = 32,
    parameter int unsigned C_TAG_DEPTH_LOG  = 4,
    parameter int unsigned C_DATA_DEPTH_LOG = 4
) (
    input logic                                  clk,
    input logic                                  reset_n,
    ddr4_v2_2_20_axi_rd_resp_packer_if.slave     bus
);

    localparam int unsigned TagDepth  = 1 << C_TAG_DEPTH_LOG;
    localparam int unsigned DataDepth = 1 << C_DATA_DEPTH_LOG;
    localparam int unsigned TagWidth  = C_ID_WIDTH + 3;
    localparam int unsigned WordWidth = 2 * C_DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBeat0 = 2'd1,
        StBeat1 = 2'd2
    } state_e;

    // ---------------------------------------------------------------------------------------
    // Tag FIFO: {id, ignore_begin, ignore_end, last}
    // ---------------------------------------------------------------------------------------
    logic [TagWidth-1:0]        tag_mem [TagDepth];
    logic [C_TAG_DEPTH_LOG:0]   tag_wr_ptr_q, tag_rd_ptr_q;
    logic                       tag_full, tag_empty, tag_push;
    logic [TagWidth-1:0]        tag_head;
    logic [C_ID_WIDTH-1:0]      head_id;
    logic                       head_ib, head_ie, head_last;

    assign tag_full  = (tag_wr_ptr_q[C_TAG_DEPTH_LOG-1:0] == tag_rd_ptr_q[C_TAG_DEPTH_LOG-1:0])
                    && (tag_wr_ptr_q[C_TAG_DEPTH_LOG] != tag_rd_ptr_q[C_TAG_DEPTH_LOG]);
    assign tag_empty = (tag_wr_ptr_q == tag_rd_ptr_q);
    assign tag_push  = bus.tag_valid & ~tag_full;
    assign tag_head  = tag_mem[tag_rd_ptr_q[C_TAG_DEPTH_LOG-1:0]];
    assign {head_id, head_ib, head_ie, head_last} = tag_head;

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr_q[C_TAG_DEPTH_LOG-1:0]] <=
                {bus.tag_id, bus.tag_ignore_begin, bus.tag_ignore_end, bus.tag_last};
        end
    end

    // ---------------------------------------------------------------------------------------
    // Data FIFO: one MC word (two beats) per entry
    // ---------------------------------------------------------------------------------------
    logic [WordWidth-1:0]       data_mem [DataDepth];
    logic [C_DATA_DEPTH_LOG:0]  data_wr_ptr_q, data_rd_ptr_q;
    logic                       data_full, data_empty, data_push;
    logic [WordWidth-1:0]       data_head;

    assign data_full  = (data_wr_ptr_q[C_DATA_DEPTH_LOG-1:0]
                         == data_rd_ptr_q[C_DATA_DEPTH_LOG-1:0])
                     && (data_wr_ptr_q[C_DATA_DEPTH_LOG] != data_rd_ptr_q[C_DATA_DEPTH_LOG]);
    assign data_empty = (data_wr_ptr_q == data_rd_ptr_q);
    assign data_push  = bus.mc_rd_valid & ~data_full;
    assign data_head  = data_mem[data_rd_ptr_q[C_DATA_DEPTH_LOG-1:0]];

    always_ff @(posedge clk) begin
        if (data_push) begin
            data_mem[data_wr_ptr_q[C_DATA_DEPTH_LOG-1:0]] <= bus.mc_rd_data;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Word state machine
    // ---------------------------------------------------------------------------------------
    state_e                     state_q, state_d;
    logic [C_ID_WIDTH-1:0]      cur_id_q;
    logic                       cur_ie_q, cur_last_q;
    logic [WordWidth-1:0]       cur_data_q;
    logic                       latch, pop, err_pulse;
    logic                       beat_valid, beat_ready, beat_fire, beat_last;
    logic [C_DATA_WIDTH-1:0]    beat_data;

    assign beat_valid = (state_q != StIdle);
    assign beat_fire  = beat_valid & beat_ready;
    assign beat_data  = (state_q == StBeat1) ? cur_data_q[WordWidth-1:C_DATA_WIDTH]
                                             : cur_data_q[C_DATA_WIDTH-1:0];
    assign beat_last  = cur_last_q
                      & ((state_q == StBeat1) | ((state_q == StBeat0) & cur_ie_q));

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        pop       = 1'b0;
        err_pulse = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!tag_empty && !data_empty) begin
                    latch = 1'b1;
                    if (!head_ib) begin
                        state_d = StBeat0;
                    end else if (!head_ie) begin
                        state_d = StBeat1;
                    end else begin
                        // Nothing to emit: retire the pair immediately and flag it.
                        pop       = 1'b1;
                        err_pulse = 1'b1;
                    end
                end
            end
            StBeat0: begin
                if (beat_fire) begin
                    if (cur_ie_q) begin
                        state_d = StIdle;
                        pop     = 1'b1;
                    end else begin
                        state_d = StBeat1;
                    end
                end
            end
            StBeat1: begin
                if (beat_fire) begin
                    state_d = StIdle;
                    pop     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cur_id_q      <= '0;
            cur_ie_q      <= 1'b0;
            cur_last_q    <= 1'b0;
            cur_data_q    <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            data_wr_ptr_q <= '0;
            data_rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                cur_id_q   <= head_id;
                cur_ie_q   <= head_ie;
                cur_last_q <= head_last;
                cur_data_q <= data_head;
            end
            if (tag_push) begin
                tag_wr_ptr_q <= tag_wr_ptr_q + {{C_TAG_DEPTH_LOG{1'b0}}, 1'b1};
            end
            if (data_push) begin
                data_wr_ptr_q <= data_wr_ptr_q + {{C_DATA_DEPTH_LOG{1'b0}}, 1'b1};
            end
            if (pop) begin
                tag_rd_ptr_q  <= tag_rd_ptr_q + {{C_TAG_DEPTH_LOG{1'b0}}, 1'b1};
                data_rd_ptr_q <= data_rd_ptr_q + {{C_DATA_DEPTH_LOG{1'b0}}, 1'b1};
            end
        end
    end

    assign bus.tag_ready       = ~tag_full;
    assign bus.mc_rd_ready     = ~data_full;
    assign bus.rresp           = 2'b00;
    assign bus.err_both_ignore = err_pulse;

    // ---------------------------------------------------------------------------------------
    // R channel output stage
    // ---------------------------------------------------------------------------------------
`ifdef DDR4_AXI_RD_RESP_SKID_EN
    logic [C_DATA_WIDTH-1:0]    skid_data_q [2];
    logic [C_ID_WIDTH-1:0]      skid_id_q   [2];
    logic                       skid_last_q [2];
    logic                       skid_wr_q, skid_rd_q;
    logic [1:0]                 skid_cnt_q;
    logic                       skid_pop;

    // Ready back to the state machine is purely registered, breaking the rready path.
    assign beat_ready = (skid_cnt_q != 2'd2);
    assign skid_pop   = bus.rvalid & bus.rready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                skid_data_q[i] <= '0;
                skid_id_q[i]   <= '0;
                skid_last_q[i] <= 1'b0;
            end
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
        end else begin
            if (beat_fire) begin
                skid_data_q[skid_wr_q] <= beat_data;
                skid_id_q[skid_wr_q]   <= cur_id_q;
                skid_last_q[skid_wr_q] <= beat_last;
                skid_wr_q              <= ~skid_wr_q;
            end
            if (skid_pop) begin
                skid_rd_q <= ~skid_rd_q;
            end
            skid_cnt_q <= skid_cnt_q + {1'b0, beat_fire} - {1'b0, skid_pop};
        end
    end

    assign bus.rvalid = (skid_cnt_q != 2'd0);
    assign bus.rdata  = skid_data_q[skid_rd_q];
    assign bus.rid    = skid_id_q[skid_rd_q];
    assign bus.rlast  = skid_last_q[skid_rd_q];
`else
    assign beat_ready = bus.rready;
    assign bus.rvalid = beat_valid;
    assign bus.rdata  = beat_data;
    assign bus.rid    = cur_id_q;
    assign bus.rlast  = beat_last;
`endif

endmodule
